// File: rtl/usb_tx_serializer.sv
// Full-speed USB 1.1 transmit engine: SYNC, PID, payload, CRC16, bit stuffing, NRZI and EOP.
// Optional: define USB_TX_DATA1_EN to accept tx_packet=5 as a DATA1 (PID 0x4B) request.
module usb_tx_serializer #(
    parameter int BIT_PERIOD  = 8,
    parameter int MAX_PAYLOAD = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_packet_data,
    input  logic [2:0] tx_packet,
    output logic       get_tx_packet_data,
    output logic       tx_transfer_active,
    output logic       tx_error,
    output logic       dplus_out,
    output logic       dminus_out
);
    localparam int            TW        = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_PERIOD - 1);
    localparam logic [6:0]    MAX_BYTES = 7'(MAX_PAYLOAD);

    typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC, EOP_SE0, EOP_J} state_t;

    state_t        state, next_field;
    logic [TW-1:0] timer;
    logic [3:0]    bit_cnt;
    logic [15:0]   shift, load_val, crc;
    logic [2:0]    ones_cnt;
    logic [7:0]    pid, req_pid;
    logic [6:0]    sent_cnt, avail;
    logic          level, next_level, is_data, req_valid, req_data;
    logic          bit_end, stuff_now, field_last, can_load, load_pop, tx_bit, crc_en;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic [15:0] r;
        r = {c[14:0], 1'b0};
        if (b ^ c[15]) r = r ^ 16'h8005;
        return r;
    endfunction

    // The shift register sends bit 0 first, so the CRC is loaded reversed to go out MSB first.
    function automatic logic [15:0] reverse16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    always_comb begin
        req_valid = 1'b1;
        req_data  = 1'b0;
        req_pid   = 8'h00;
        case (tx_packet)
            3'd1: begin req_data = 1'b1; req_pid = 8'hC3; end
            3'd2: req_pid = 8'hD2;
            3'd3: req_pid = 8'h5A;
            3'd4: req_pid = 8'h1E;
`ifdef USB_TX_DATA1_EN
            3'd5: begin req_data = 1'b1; req_pid = 8'h4B; end
`endif
            default: req_valid = 1'b0;
        endcase
    end

    assign bit_end    = (timer == BIT_LAST);
    assign avail      = (buffer_occupancy > MAX_BYTES) ? MAX_BYTES : buffer_occupancy;
    assign can_load   = (avail != 7'd0) && (sent_cnt < MAX_BYTES);
    assign stuff_now  = (ones_cnt == 3'd6) && (state inside {SYNC, PID, DATA, CRC});
    assign field_last = (state == CRC) ? (bit_cnt == 4'd15) : (bit_cnt == 4'd7);

    // What follows the current field once its last bit has been on the wire.
    always_comb begin
        next_field = state;
        load_val   = shift;
        load_pop   = 1'b0;
        case (state)
            SYNC: begin
                next_field = PID;
                load_val   = {8'h00, pid};
            end
            PID, DATA: begin
                if (state == PID && !is_data) begin
                    next_field = EOP_SE0;
                end else if (can_load) begin
                    next_field = DATA;
                    load_val   = {8'h00, tx_packet_data};
                    load_pop   = 1'b1;
                end else begin
                    next_field = CRC;
                    load_val   = reverse16(~crc);
                end
            end
            CRC:     next_field = EOP_SE0;
            default: next_field = state;
        endcase
    end

    always_comb begin
        tx_bit = 1'b0;
        crc_en = 1'b0;
        if (!stuff_now) begin
            if (field_last) begin
                tx_bit = load_val[0];
                crc_en = (next_field == DATA);
            end else begin
                tx_bit = shift[1];
                crc_en = (state == DATA);
            end
        end
        next_level = tx_bit ? level : ~level;
    end

    // NOTE: every register here is state, so all assignments are non-blocking; combinational helpers live in always_comb.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state              <= IDLE;
            timer              <= '0;
            bit_cnt            <= '0;
            shift              <= '0;
            crc                <= 16'hFFFF;
            ones_cnt           <= '0;
            pid                <= '0;
            is_data            <= 1'b0;
            sent_cnt           <= '0;
            level              <= 1'b1;
            get_tx_packet_data <= 1'b0;
            tx_transfer_active <= 1'b0;
            tx_error           <= 1'b0;
            dplus_out          <= 1'b1;
            dminus_out         <= 1'b0;
        end else begin
            get_tx_packet_data <= 1'b0;
            tx_error           <= 1'b0;
            timer              <= bit_end ? '0 : timer + 1'b1;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (tx_packet != 3'd0) begin
                        if (!req_valid) begin
                            tx_error <= 1'b1;
                        end else begin
                            state              <= SYNC;
                            tx_transfer_active <= 1'b1;
                            pid                <= req_pid;
                            is_data            <= req_data;
                            shift              <= 16'h0080;
                            bit_cnt            <= '0;
                            crc                <= 16'hFFFF;
                            sent_cnt           <= '0;
                            ones_cnt           <= '0;
                            // First SYNC bit is a 0, so the line leaves J for K right away.
                            level              <= 1'b0;
                            dplus_out          <= 1'b0;
                            dminus_out         <= 1'b1;
                        end
                    end
                end
                SYNC, PID, DATA, CRC: begin
                    if (bit_end) begin
                        if (!stuff_now && field_last && next_field == EOP_SE0) begin
                            state      <= EOP_SE0;
                            bit_cnt    <= '0;
                            ones_cnt   <= '0;
                            dplus_out  <= 1'b0;
                            dminus_out <= 1'b0;
                        end else begin
                            level      <= next_level;
                            dplus_out  <= next_level;
                            dminus_out <= ~next_level;
                            ones_cnt   <= tx_bit ? ones_cnt + 1'b1 : 3'd0;
                            if (crc_en) crc <= crc_step(crc, tx_bit);
                            if (!stuff_now) begin
                                if (field_last) begin
                                    state   <= next_field;
                                    shift   <= load_val;
                                    bit_cnt <= '0;
                                    if (load_pop) begin
                                        get_tx_packet_data <= 1'b1;
                                        sent_cnt           <= sent_cnt + 1'b1;
                                    end
                                end else begin
                                    shift   <= shift >> 1;
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                        end
                    end
                end
                EOP_SE0: begin
                    if (bit_end) begin
                        if (bit_cnt == 4'd1) begin
                            state      <= EOP_J;
                            level      <= 1'b1;
                            dplus_out  <= 1'b1;
                            dminus_out <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                EOP_J: begin
                    if (bit_end) begin
                        state              <= IDLE;
                        tx_transfer_active <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_tx_serializer.sv
// Directed bench for usb_tx_serializer: line symbols per bit time, pops, active length, errors, reset.
module tb_usb_tx_serializer;
    localparam int BP = 8;
    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [6:0] buffer_occupancy = 7'd0;
    logic [7:0] tx_packet_data = 8'h00;
    logic [2:0] tx_packet = 3'd0;
    logic       get_tx_packet_data, tx_transfer_active, tx_error, dplus_out, dminus_out;

    int      checks = 0;
    int      failures = 0;
    int      pops = 0;
    byte_q_t buf_q;

    usb_tx_serializer #(.BIT_PERIOD(BP), .MAX_PAYLOAD(64)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .buffer_occupancy   (buffer_occupancy),
        .tx_packet_data     (tx_packet_data),
        .tx_packet          (tx_packet),
        .get_tx_packet_data (get_tx_packet_data),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error),
        .dplus_out          (dplus_out),
        .dminus_out         (dminus_out)
    );

    always #5 clk = ~clk;

    // Data buffer model: pops on the strobe, presents head byte and occupancy.
    always @(negedge clk) begin
        if (get_tx_packet_data) begin
            pops++;
            if (buf_q.size() > 0) void'(buf_q.pop_front());
        end
        buffer_occupancy = 7'(buf_q.size());
        tx_packet_data   = (buf_q.size() > 0) ? buf_q[0] : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic byte line_sym();
        case ({dplus_out, dminus_out})
            2'b10:   return "J";
            2'b01:   return "K";
            2'b00:   return "0";
            default: return "X";
        endcase
    endfunction

    // Reference encoder for data packets: bits -> stuffing -> NRZI -> EOP symbols.
    function automatic string encode(input logic [7:0] pid, input byte_q_t pl);
        logic        bits[$];
        logic [15:0] crc;
        logic [7:0]  sync_b;
        logic [7:0]  cur;
        logic        level, fb;
        int          ones;
        string       s;
        crc = 16'hFFFF; sync_b = 8'h80; level = 1'b1; ones = 0; s = "";
        for (int i = 0; i < 8; i++) bits.push_back(sync_b[i]);
        for (int i = 0; i < 8; i++) bits.push_back(pid[i]);
        foreach (pl[k]) begin
            cur = pl[k];
            for (int i = 0; i < 8; i++) begin
                fb  = cur[i] ^ crc[15];
                crc = {crc[14:0], 1'b0};
                if (fb) crc = crc ^ 16'h8005;
                bits.push_back(cur[i]);
            end
        end
        for (int i = 15; i >= 0; i--) bits.push_back(~crc[i]);
        foreach (bits[k]) begin
            if (!bits[k]) level = ~level;
            s = level ? {s, "J"} : {s, "K"};
            ones = bits[k] ? ones + 1 : 0;
            if (ones == 6) begin
                level = ~level;
                s = level ? {s, "J"} : {s, "K"};
                ones = 0;
            end
        end
        return {s, "00J"};
    endfunction

    task automatic run_packet(input string name, input logic [2:0] code, input string exp,
                              input int exp_pops, input int inject_at);
        int bad = 0;
        int act = 0;
        int clk_i = 0;
        pops = 0;
        @(negedge clk);
        tx_packet = code;
        @(negedge clk);
        for (int i = 0; i < exp.len(); i++) begin
            for (int c = 0; c < BP; c++) begin
                if (clk_i != 0) @(negedge clk);
                tx_packet = (clk_i == inject_at) ? 3'd2 : 3'd0;
                if (line_sym() != exp[i]) bad++;
                if (tx_transfer_active) act++;
                clk_i++;
            end
        end
        tx_packet = 3'd0;
        check({"line_", name}, bad, 0);
        check({"active_len_", name}, act, exp.len() * BP);
        @(negedge clk);
        check({"active_end_", name}, tx_transfer_active, 1'b0);
        check({"idle_j_", name}, {dplus_out, dminus_out}, 2'b10);
        check({"pops_", name}, pops, exp_pops);
    endtask

    initial begin
        logic [2:0] bad_codes[$];
        string      exp_s;
        int         act;

        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_dplus", dplus_out, 1'b1);
        check("rst_dminus", dminus_out, 1'b0);
        check("rst_active", tx_transfer_active, 1'b0);
        check("rst_get", get_tx_packet_data, 1'b0);
        check("rst_error", tx_error, 1'b0);
        n_rst = 1'b1;

        bad_codes = {3'd6, 3'd7};
`ifndef USB_TX_DATA1_EN
        bad_codes.push_back(3'd5);
`endif
        foreach (bad_codes[k]) begin
            @(negedge clk);
            tx_packet = bad_codes[k];
            @(negedge clk);
            tx_packet = 3'd0;
            check($sformatf("err_pulse_%0d", bad_codes[k]), tx_error, 1'b1);
            check($sformatf("err_active_%0d", bad_codes[k]), tx_transfer_active, 1'b0);
            @(negedge clk);
            check($sformatf("err_clear_%0d", bad_codes[k]), tx_error, 1'b0);
            check($sformatf("err_line_%0d", bad_codes[k]), {dplus_out, dminus_out}, 2'b10);
        end

        run_packet("ack",   3'd2, "KJKJKJKKJJKJJKKK00J", 0, -1);
        run_packet("nak",   3'd3, "KJKJKJKKJJKKKJJK00J", 0, -1);
        run_packet("stall", 3'd4, "KJKJKJKKJJJJJKJK00J", 0, -1);
        run_packet("data0_empty", 3'd1, "KJKJKJKKKKJKJKKKJKJKJKJKJKJKJKJK00J", 0, -1);

        buf_q = {8'h4D, 8'hAA, 8'hBE};
        exp_s = encode(8'hC3, buf_q);
        @(negedge clk);
        run_packet("data0_3b", 3'd1, exp_s, 3, -1);
        check("buf_drained", buffer_occupancy, 7'd0);

        buf_q = {8'hFF, 8'hFF};
        exp_s = encode(8'hC3, buf_q);
        @(negedge clk);
        run_packet("data0_ff", 3'd1, exp_s, 2, 40);
        act = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_transfer_active) act++;
        end
        check("no_retrigger", act, 0);

        buf_q = {8'h12, 8'h34};
        @(negedge clk);
        @(negedge clk);
        tx_packet = 3'd1;
        @(negedge clk);
        tx_packet = 3'd0;
        repeat (30) @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        check("midrst_active", tx_transfer_active, 1'b0);
        check("midrst_line", {dplus_out, dminus_out}, 2'b10);
        n_rst = 1'b1;
        buf_q.delete();
        @(negedge clk);
        run_packet("ack_after_rst", 3'd2, "KJKJKJKKJJKJJKKK00J", 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/usb_tx_serializer.md
Name: usb_tx_serializer

Overview:
- Full-speed USB 1.1 transmit engine.
- Turns a packet request into a complete packet on the D+/D- lines: SYNC, PID, optional payload, CRC16, NRZI coding, bit stuffing and EOP.
- Payload bytes are pulled from the shared TX/RX data buffer (data_buffer) through a pop handshake.
- Sits between the protocol controller (which issues tx_packet) and the bus output drivers.

Parameters:
- BIT_PERIOD, 8, clk cycles per USB bit time; every line state is held exactly this long.
- MAX_PAYLOAD, 64, maximum data bytes per packet; buffer_occupancy above this is clamped.

Ports:
- clk  input  1  system clock
- n_rst  input  1  reset, active-low, synchronous
- buffer_occupancy  input  7  bytes currently held in the data buffer
- tx_packet_data  input  8  head byte of the buffer, valid whenever buffer_occupancy>0
- tx_packet  input  3  request code: 0 none, 1 DATA0, 2 ACK, 3 NAK, 4 STALL, others invalid
- get_tx_packet_data  output  1  one-clk pop strobe to the buffer
- tx_transfer_active  output  1  high while a packet is being driven
- tx_error  output  1  one-clk pulse on an invalid request
- dplus_out  output  1  D+ line
- dminus_out  output  1  D- line

Behaviour:
- One clock (clk); reset is synchronous and active-low (n_rst low sampled at a rising clk edge).
- Reset values: get_tx_packet_data=0, tx_transfer_active=0, tx_error=0, dplus_out=1, dminus_out=0 (idle J). NRZI level=J, stuff counter=0, state=IDLE.
- A reset mid-packet aborts the packet immediately and returns to idle J.
- FSM states: IDLE, SYNC, PID, DATA, CRC, EOP_SE0, EOP_J.
- IDLE: tx_packet is sampled every clk. Any nonzero value is taken as a request; tx_packet is ignored in all other states.
- Invalid code (5, 6, 7): tx_error=1 for exactly one clk, no transmission, stay in IDLE.
- Valid request: tx_transfer_active rises the next clk and the first SYNC bit appears on the lines in that same clk.
- Field order: SYNC byte 0x80, then PID byte.
  - PID bytes: DATA0=0xC3, ACK=0xD2, NAK=0x5A, STALL=0x1E.
  - Every byte is sent LSB first.
- Handshake packets (ACK, NAK, STALL): PID then straight to EOP.
- DATA0 packets: PID, then payload bytes, then 16 CRC bits.
  - At each byte boundary, if buffer_occupancy>0 (and fewer than MAX_PAYLOAD bytes sent), the engine loads tx_packet_data into its shift register and pulses get_tx_packet_data for one clk in that same cycle.
  - If buffer_occupancy=0 at a byte boundary, the engine moves to CRC.
  - Empty buffer at request gives a zero-length DATA0; its CRC is 0x0000.
- CRC16:
  - Initial value 0xFFFF; per payload bit b: fb=b^crc[15], crc=crc<<1, and if fb then crc^=0x8005.
  - Transmit ~crc, bit 15 first.
- Bit stuffing applies from SYNC through CRC.
  - After six consecutive 1s, one 0 bit time is inserted; the counter clears on any 0, including the stuffed 0.
  - No data is consumed during a stuffed bit.
- NRZI: a 0 toggles the line between J (1,0) and K (0,1); a 1 holds it. SYNC therefore appears as KJKJKJKK.
- EOP: SE0 (0,0) for 2 bit times, then J for 1 bit time. tx_transfer_active falls after that final J bit and the engine returns to IDLE.
- Back-to-back: a new request is accepted on the first IDLE clk after tx_transfer_active falls.
- Buffer occupancy changing mid-packet is honoured only at byte boundaries.

Optional Feature:
- Macro USB_TX_DATA1_EN.
- Defined: tx_packet=5 requests DATA1 (PID byte 0x4B), with a payload/CRC sequence identical to DATA0; codes 6 and 7 remain invalid.
- Undefined: code 5 is invalid and pulses tx_error.

Test Plan:
- Reset: hold n_rst=0 for 2 clks -> dplus_out=1, dminus_out=0, all other outputs 0.
- Buffer loaded with 0x4D, 0xAA, 0xBE, then tx_packet=1 for one clk:
  - SYNC, PID 0xC3, 3 payload bytes, correct CRC16, EOP.
  - Exactly 3 get_tx_packet_data pulses; tx_transfer_active lasts (8+8+24+16+stuffed+3)*BIT_PERIOD clks.
- tx_packet=1 with empty buffer -> SYNC, 0xC3, CRC bits 0x0000 on the wire (16 zeros), EOP; no get_tx_packet_data pulse.
- tx_packet=2/3/4 -> PID 0xD2/0x5A/0x1E on the wire, then EOP; no pops; tx_transfer_active covers 19 bit times.
- tx_packet=7 -> tx_error high for exactly 1 clk, lines stay J, tx_transfer_active stays 0.
- Payload 0xFF, 0xFF -> a stuffed 0 appears after every run of six 1s, CRC still correct; request during an active packet is ignored.
